// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller: Moore-FSM control unit for a multi-cycle RV32I datapath.
// Inputs : clk, reset (async, active-high), opcode/f3/f7 decoded instruction
//          fields, zero (ALU zero flag, used only for the branch PC write).
// Outputs: adr_src, mem_write, ir_write, imm_src, alu_src_a, alu_src_b,
//          alu_function, result_src, reg_write, pc_write, old_pc_write.
module multi_cycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] f3,
    input  logic [6:0] f7,
    input  logic       zero,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [2:0] imm_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_function,
    output logic [1:0] result_src,
    output logic       reg_write,
    output logic       pc_write,
    output logic       old_pc_write
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_EXEC_R,
        S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_JALR_CALC, S_JALR_JUMP, S_LUI
    } state_t;
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011,
                           OP_SW = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111;
    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3,
                           ALU_SLT = 3'd4, ALU_XOR = 3'd5, ALU_SLTU = 3'd6;
    state_t     r_state, w_next;
    logic [2:0] w_f3_op, w_br_op;
    logic       w_taken, w_unused;
    assign w_unused = ^{f7[6], f7[4:0]};
    assign w_f3_op = (f3 == 3'b111) ? ALU_AND :
                     (f3 == 3'b110) ? ALU_OR  :
                     (f3 == 3'b100) ? ALU_XOR :
                     (f3 == 3'b010) ? ALU_SLT :
                     (f3 == 3'b011) ? ALU_SLTU : ALU_ADD;
    assign w_br_op = (f3 == 3'b100 || f3 == 3'b101) ? ALU_SLT : ALU_SUB;
    // beq/bge take on zero, bne/blt on !zero; other f3 never branch
    assign w_taken = (f3 == 3'b000 || f3 == 3'b101) ? zero :
                     (f3 == 3'b001 || f3 == 3'b100) ? !zero : 1'b0;
    always_ff @(posedge clk or posedge reset)
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    always_comb begin
        w_next       = S_FETCH;
        adr_src      = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        imm_src      = 3'b000;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        alu_function = ALU_ADD;
        result_src   = 2'b00;
        reg_write    = 1'b0;
        pc_write     = 1'b0;
        old_pc_write = 1'b0;
        case (r_state)
            S_FETCH: begin
                ir_write     = 1'b1;
                old_pc_write = 1'b1;
                alu_src_b    = 2'b10;
                result_src   = 2'b10;
                pc_write     = 1'b1;
                w_next       = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = (opcode == OP_JAL) ? 3'b011 : 3'b010;
                w_next    = (opcode == OP_R)    ? S_EXEC_R    :
                            (opcode == OP_I)    ? S_EXEC_I    :
                            (opcode == OP_LW || opcode == OP_SW) ? S_MEM_ADR :
                            (opcode == OP_BR)   ? S_BRANCH    :
                            (opcode == OP_JAL)  ? S_JAL       :
                            (opcode == OP_JALR) ? S_JALR_CALC :
                            (opcode == OP_LUI)  ? S_LUI       : S_FETCH;
            end
            S_MEM_ADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = (opcode == OP_SW) ? 3'b001 : 3'b000;
                w_next    = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                adr_src = 1'b1;
                w_next  = S_MEM_WB;
            end
            S_MEM_WB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEM_WRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a    = 2'b10;
                alu_function = (f3 == 3'b000 && f7[5]) ? ALU_SUB : w_f3_op;
                w_next       = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a    = 2'b10;
                alu_src_b    = 2'b01;
                alu_function = w_f3_op;
                w_next       = S_ALU_WB;
            end
            S_ALU_WB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a    = 2'b10;
                alu_function = w_br_op;
                pc_write     = w_taken;
            end
            S_JAL, S_JALR_JUMP: begin
                // ALUOut holds the target; ALU computes old PC + 4 for the link
                pc_write  = 1'b1;
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                w_next    = S_ALU_WB;
            end
            S_JALR_CALC: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                w_next    = S_JALR_JUMP;
            end
            S_LUI: begin
                imm_src    = 3'b100;
                result_src = 2'b11;
                reg_write  = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
        // enables drop the instant reset rises, independent of the clock
        if (reset) begin
            mem_write    = 1'b0;
            ir_write     = 1'b0;
            reg_write    = 1'b0;
            pc_write     = 1'b0;
            old_pc_write = 1'b0;
        end
    end
endmodule

// File: tb/tb_multi_cycle_controller.sv
// tb_multi_cycle_controller: vector, directed and random checks of multi_cycle_controller.
module tb_multi_cycle_controller;
    typedef struct packed {
        logic       adr, mw, irw;
        logic [2:0] imm;
        logic [1:0] a, b;
        logic [2:0] alu;
        logic [1:0] res;
        logic       rw, pcw, opw;
    } ctl_t;
    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       z;
        int         lat;
    } vec_t;
    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                           SLT = 3'd4, XOR_ = 3'd5, SLTU = 3'd6;
    logic clk = 1'b0, reset = 1'b1, zero = 1'b0;
    logic [6:0] opcode = '0, f7 = '0;
    logic [2:0] f3 = '0;
    logic adr_src, mem_write, ir_write, reg_write, pc_write, old_pc_write;
    logic [2:0] imm_src, alu_function;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    ctl_t dut_w, exp_q[$];
    int errors = 0, checks = 0;
    vec_t vecs[14];

    multi_cycle_controller dut (
        .clk(clk), .reset(reset), .opcode(opcode), .f3(f3), .f7(f7), .zero(zero),
        .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write), .imm_src(imm_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_function(alu_function),
        .result_src(result_src), .reg_write(reg_write), .pc_write(pc_write),
        .old_pc_write(old_pc_write)
    );
    assign dut_w = {adr_src, mem_write, ir_write, imm_src, alu_src_a, alu_src_b,
                    alu_function, result_src, reg_write, pc_write, old_pc_write};
    always #5 clk = ~clk;

    function automatic ctl_t cw(logic adr, logic mw, logic irw, logic [2:0] imm, logic [1:0] a,
                                logic [1:0] b, logic [2:0] alu, logic [1:0] res,
                                logic rw, logic pcw, logic opw);
        cw = {adr, mw, irw, imm, a, b, alu, res, rw, pcw, opw};
    endfunction

    function automatic logic [2:0] f3_alu(logic [2:0] f);
        case (f)
            3'b111: f3_alu = AND_;
            3'b110: f3_alu = OR_;
            3'b100: f3_alu = XOR_;
            3'b010: f3_alu = SLT;
            3'b011: f3_alu = SLTU;
            default: f3_alu = ADD;
        endcase
    endfunction

    // Expected control word for every cycle of one instruction, FETCH first
    function automatic void build(logic [6:0] op, logic [2:0] f, logic [6:0] f7v, logic z);
        ctl_t wb = cw(0,0,0,0,0,0,ADD,0,1,0,0);
        ctl_t link = cw(0,0,0,0,1,2,ADD,0,0,1,0);
        logic tk;
        exp_q.delete();
        exp_q.push_back(cw(0,0,1,0,0,2,ADD,2,0,1,1));
        exp_q.push_back(cw(0,0,0,(op == 7'b1101111) ? 3'd3 : 3'd2,1,1,ADD,0,0,0,0));
        case (op)
            7'b0110011: begin
                exp_q.push_back(cw(0,0,0,0,2,0,(f == 0 && f7v[5]) ? SUB : f3_alu(f),0,0,0,0));
                exp_q.push_back(wb);
            end
            7'b0010011: begin
                exp_q.push_back(cw(0,0,0,0,2,1,f3_alu(f),0,0,0,0));
                exp_q.push_back(wb);
            end
            7'b0000011: begin
                exp_q.push_back(cw(0,0,0,0,2,1,ADD,0,0,0,0));
                exp_q.push_back(cw(1,0,0,0,0,0,ADD,0,0,0,0));
                exp_q.push_back(cw(0,0,0,0,0,0,ADD,1,1,0,0));
            end
            7'b0100011: begin
                exp_q.push_back(cw(0,0,0,1,2,1,ADD,0,0,0,0));
                exp_q.push_back(cw(1,1,0,0,0,0,ADD,0,0,0,0));
            end
            7'b1100011: begin
                tk = (f == 3'b000 || f == 3'b101) ? z : (f == 3'b001 || f == 3'b100) ? !z : 1'b0;
                exp_q.push_back(cw(0,0,0,0,2,0,(f == 3'b100 || f == 3'b101) ? SLT : SUB,0,0,tk,0));
            end
            7'b1101111: begin
                exp_q.push_back(link);
                exp_q.push_back(wb);
            end
            7'b1100111: begin
                exp_q.push_back(cw(0,0,0,0,2,1,ADD,0,0,0,0));
                exp_q.push_back(link);
                exp_q.push_back(wb);
            end
            7'b0110111: exp_q.push_back(cw(0,0,0,4,0,0,ADD,3,1,0,0));
            default: ;
        endcase
    endfunction

    task automatic check(string name, int cyc, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc %0d: got %h want %h", name, cyc, got, want);
        end
    endtask

    task automatic set_in(logic [6:0] op, logic [2:0] f, logic [6:0] f7v, logic z);
        opcode = op; f3 = f; f7 = f7v; zero = z;
    endtask

    // Called #1 after a posedge with the DUT in FETCH; returns the same way
    task automatic run_checked(string name, logic [6:0] op, logic [2:0] f, logic [6:0] f7v, logic z);
        build(op, f, f7v, z);
        set_in(op, f, f7v, z);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            check(name, i, 32'(dut_w), 32'(exp_q[i]));
            @(posedge clk); #1;
        end
    endtask

    task automatic measure(string name, logic [6:0] op, logic [2:0] f, logic [6:0] f7v, logic z, int lat);
        int n = 0;
        set_in(op, f, f7v, z);
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ir_write && n < 12);
        check(name, 0, 32'(n), 32'(lat));
    endtask

    initial begin
        vecs[0]  = '{7'b0110011, 3'b000, 7'b0100000, 1'b0, 4};
        vecs[1]  = '{7'b0110011, 3'b000, 7'b0000000, 1'b0, 4};
        vecs[2]  = '{7'b0110011, 3'b011, 7'b0100000, 1'b1, 4};
        vecs[3]  = '{7'b0010011, 3'b000, 7'b0100000, 1'b0, 4};
        vecs[4]  = '{7'b0010011, 3'b100, 7'b0000000, 1'b0, 4};
        vecs[5]  = '{7'b0000011, 3'b010, 7'b0000000, 1'b0, 5};
        vecs[6]  = '{7'b0100011, 3'b010, 7'b0000000, 1'b0, 4};
        vecs[7]  = '{7'b1100011, 3'b000, 7'b0000000, 1'b1, 3};
        vecs[8]  = '{7'b1100011, 3'b000, 7'b0000000, 1'b0, 3};
        vecs[9]  = '{7'b1100011, 3'b100, 7'b0000000, 1'b0, 3};
        vecs[10] = '{7'b1101111, 3'b000, 7'b0000000, 1'b0, 4};
        vecs[11] = '{7'b1100111, 3'b000, 7'b0000000, 1'b0, 5};
        vecs[12] = '{7'b0110111, 3'b000, 7'b0000000, 1'b0, 3};
        vecs[13] = '{7'b0000000, 3'b000, 7'b0000000, 1'b0, 2};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_enables", i, 32'({mem_write, ir_write, reg_write, pc_write, old_pc_write}), 0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 14; i++) begin
            run_checked("vector", vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z);
            measure("latency", vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z, vecs[i].lat);
        end
        set_in(7'b1100011, 3'b000, 7'b0, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        check("br_zero0", 0, 32'(pc_write), 0);
        zero = 1'b1; #1;
        check("br_zero1", 1, 32'(pc_write), 1);
        zero = 1'b0; #1;
        check("br_zero0b", 2, 32'(pc_write), 0);
        @(posedge clk); #1;
        set_in(7'b0100011, 3'b010, 7'b0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        check("memw_before_rst", 0, 32'(mem_write), 1);
        #1 reset = 1'b1;
        #1 check("memw_async_rst", 0, 32'({mem_write, ir_write, reg_write, pc_write, old_pc_write}), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_checked("after_rst", 7'b0110111, 3'b000, 7'b0, 1'b0);
        for (int i = 0; i < 150; i++) begin
            logic [6:0] ops [9];
            ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                    7'b1101111, 7'b1100111, 7'b0110111, 7'($urandom)};
            run_checked("random", ops[$urandom_range(8)], 3'($urandom), 7'($urandom), 1'($urandom));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multi_cycle_controller.md
Name: multi_cycle_controller

Overview:
- Control unit for the multi-cycle RV32I core. It is the counterpart of the datapath.
- Consumes the decoded instruction fields (opcode, f3, f7) and the ALU zero flag.
- Produces every mux select and write enable the datapath needs, through a Moore FSM.
- Branch PC write is the only output with a combinational dependency on zero.

Parameters:
- none

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- opcode  input  7  instruction[6:0].
- f3  input  3  instruction[14:12].
- f7  input  7  instruction[31:25].
- zero  input  1  ALU zero flag, combinational from current ALU operands.
- adr_src  output  1  memory address select: 0=PC, 1=result.
- mem_write  output  1  memory write enable.
- ir_write  output  1  IR load enable.
- imm_src  output  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U.
- alu_src_a  output  2  ALU A select: 00 PC, 01 old PC, 10 reg A.
- alu_src_b  output  2  ALU B select: 00 reg B, 01 immediate, 10 constant 4.
- alu_function  output  3  ALU op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 101 XOR, 110 SLTU.
- result_src  output  2  result select: 00 ALUOut register, 01 MDR, 10 ALU direct, 11 immediate.
- reg_write  output  1  register file write enable.
- pc_write  output  1  PC load enable.
- old_pc_write  output  1  old PC load enable.

Behaviour:
- Reset and defaults:
  - reset (asynchronous) forces state=FETCH.
  - While reset=1, all enables (mem_write, ir_write, reg_write, pc_write, old_pc_write) are 0.
  - Outside reset, any output not listed for a state is 0.
- FETCH:
  - adr_src=0, ir_write=1, old_pc_write=1.
  - a=00, b=10, ADD, result_src=10, pc_write=1.
  - Next state: DECODE.
- DECODE:
  - a=01, b=01, ADD.
  - imm_src=J if opcode=1101111, else B. ALUOut latches the branch/jal target.
  - Next state by opcode:
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 0000011 or 0100011 -> MEM_ADR
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR_CALC
    - 0110111 -> LUI
    - any other opcode -> FETCH (NOP).
- MEM_ADR:
  - a=10, b=01, ADD; imm_src=S for store, I for load.
  - Next state: MEM_READ for load, MEM_WRITE for store.
- MEM_READ: adr_src=1, result_src=00. Next state: MEM_WB.
- MEM_WB: result_src=01, reg_write=1. Next state: FETCH.
- MEM_WRITE: adr_src=1, result_src=00, mem_write=1. Next state: FETCH.
- EXEC_R:
  - a=10, b=00, op from f3/f7.
  - f3=000: f7[5]=0 gives ADD, f7[5]=1 gives SUB.
  - 111 AND, 110 OR, 100 XOR, 010 SLT, 011 SLTU; any other f3 gives ADD.
  - Next state: ALU_WB.
- EXEC_I:
  - a=10, b=01, imm_src=I.
  - Same f3 map as EXEC_R, but f7 is ignored (000 is always ADD).
  - Next state: ALU_WB.
- ALU_WB: result_src=00, reg_write=1. Next state: FETCH.
- BRANCH:
  - a=10, b=00, result_src=00.
  - f3 decode:
    - 000: SUB, taken=zero.
    - 001: SUB, taken=!zero.
    - 100: SLT, taken=!zero.
    - 101: SLT, taken=zero.
    - other f3: SUB, never taken.
  - pc_write=taken, combinational in this state only.
  - Next state: FETCH.
- JAL: result_src=00, pc_write=1, a=01, b=10, ADD. Next state: ALU_WB (ALUOut now holds old PC+4).
- JALR_CALC: a=10, b=01, imm_src=I, ADD. Next state: JALR_JUMP.
- JALR_JUMP: result_src=00, pc_write=1, a=01, b=10, ADD. Next state: ALU_WB.
- LUI: imm_src=100, result_src=11, reg_write=1. Next state: FETCH.
- Latency in cycles including FETCH:
  - R, I, sw, jal: 4.
  - lw, jalr: 5.
  - branch, lui: 3.
  - unknown opcode: 2.
- Reset mid-instruction aborts the instruction immediately. The next instruction begins with FETCH on the first edge after reset deasserts.
- No illegal states are reachable. Unencoded state values go to FETCH.

Test Plan:
- Reset held 3 cycles, then released -> all enables 0 during reset; first cycle after release shows ir_write=1, pc_write=1, old_pc_write=1, alu_src_b=10.
- opcode=0110011, f3=000, f7=0100000 -> EXEC_R drives alu_function=001; ALU_WB asserts reg_write=1 with result_src=00; FETCH recurs 4 cycles after the first.
- lw (0000011) -> states FETCH, DECODE, MEM_ADR (imm_src=000), MEM_READ (adr_src=1), MEM_WB (result_src=01, reg_write=1); 5 cycles; sw variant asserts mem_write=1 for exactly 1 cycle with imm_src=001.
- Branch, f3=000 with zero=1 -> pc_write=1 in BRANCH; zero=0 -> pc_write=0.
- Branch, f3=100 -> alu_function=100; zero=0 gives pc_write=1.
- Toggle zero mid-BRANCH cycle -> pc_write follows zero combinationally.
- jal (1101111) -> DECODE imm_src=011; JAL asserts pc_write=1, result_src=00; ALU_WB asserts reg_write=1.
- lui (0110111) -> LUI asserts result_src=11, imm_src=100, reg_write=1, then FETCH; 3 cycles total.
- Assert reset during MEM_WRITE -> mem_write drops to 0 immediately, with no clock edge required; FETCH follows release.
